// File: rtl/vga_frame_gen.sv
// vga_frame_gen: parametrised VGA timing generator with a bouncing box over a programmable background.
// Ports: i_VGA_CLK/i_rst (async, active-high); i_enable lets the box move at frame boundaries;
//   i_box_rgb/i_bg_rgb are {R,G,B} colours; o_VGA_* / o_BLANK_N / o_SYNC_N drive the DAC directly;
//   o_Sx/o_Sy report the pixel currently on the pins; o_frame_start pulses with pixel (0,0).
// Optional macro VGA_TEST_PATTERN_EN adds i_pattern_sel, which swaps the background for 8 colour bars.
// All outputs are registered: one cycle from counter value to pins. No backpressure (free-running source).
module vga_frame_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 10,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 1
) (
  input  logic                   i_VGA_CLK,
  input  logic                   i_rst,
  input  logic                   i_enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   i_pattern_sel,
`endif
  input  logic [3*COLOR_W-1:0]   i_box_rgb,
  input  logic [3*COLOR_W-1:0]   i_bg_rgb,
  output logic [COLOR_W-1:0]     o_VGA_R,
  output logic [COLOR_W-1:0]     o_VGA_G,
  output logic [COLOR_W-1:0]     o_VGA_B,
  output logic                   o_VGA_HS,
  output logic                   o_VGA_VS,
  output logic                   o_BLANK_N,
  output logic                   o_SYNC_N,
  output logic [CNT_W-1:0]       o_Sx,
  output logic [CNT_W-1:0]       o_Sy,
  output logic                   o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Everything compared or summed is widened by one bit so bx+BOX_SIZE+BOX_STEP cannot wrap.
  localparam logic [CNT_W:0] H_ACT_W = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_ACT_W = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W:0] BOX_W   = (CNT_W+1)'(BOX_SIZE);
  localparam logic [CNT_W:0] STEP_W  = (CNT_W+1)'(BOX_STEP);
  localparam logic           SYNC_ON = (SYNC_POL != 0);

  logic [CNT_W-1:0] sx, sy;
  logic [CNT_W-1:0] bx, by, bx_nxt, by_nxt;
  logic             dx, dy, dx_nxt, dy_nxt;
  logic [CNT_W:0]   sx_w, sy_w, bx_w, by_w;
  logic             frame_end, de, hs_act, vs_act, in_box;
  logic [3*COLOR_W-1:0] bg_rgb, pix_rgb;

  assign sx_w = {1'b0, sx};
  assign sy_w = {1'b0, sy};
  assign bx_w = {1'b0, bx};
  assign by_w = {1'b0, by};

  assign frame_end = (sx == H_LAST) && (sy == V_LAST);

  // Raster counters
  always_ff @(posedge i_VGA_CLK or posedge i_rst) begin
    if (i_rst) begin
      sx <= '0;
      sy <= '0;
    end else if (sx == H_LAST) begin
      sx <= '0;
      sy <= (sy == V_LAST) ? '0 : sy + 1'b1;
    end else begin
      sx <= sx + 1'b1;
    end
  end

  // Bounce rule per axis: reverse when the next step would push the far edge past the
  // active area, or the near edge below zero.
  always_comb begin
    bx_nxt = bx;
    dx_nxt = dx;
    if (dx) begin
      if (bx_w + BOX_W + STEP_W > H_ACT_W) begin
        dx_nxt = 1'b0;
        bx_nxt = CNT_W'(bx_w - STEP_W);
      end else begin
        bx_nxt = CNT_W'(bx_w + STEP_W);
      end
    end else if (bx_w < STEP_W) begin
      dx_nxt = 1'b1;
      bx_nxt = CNT_W'(bx_w + STEP_W);
    end else begin
      bx_nxt = CNT_W'(bx_w - STEP_W);
    end
  end

  always_comb begin
    by_nxt = by;
    dy_nxt = dy;
    if (dy) begin
      if (by_w + BOX_W + STEP_W > V_ACT_W) begin
        dy_nxt = 1'b0;
        by_nxt = CNT_W'(by_w - STEP_W);
      end else begin
        by_nxt = CNT_W'(by_w + STEP_W);
      end
    end else if (by_w < STEP_W) begin
      dy_nxt = 1'b1;
      by_nxt = CNT_W'(by_w + STEP_W);
    end else begin
      by_nxt = CNT_W'(by_w - STEP_W);
    end
  end

  // Position only changes on the last pixel of a frame, so a whole frame is drawn
  // with one box position (no tearing).
  always_ff @(posedge i_VGA_CLK or posedge i_rst) begin
    if (i_rst) begin
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
    end else if (frame_end && i_enable) begin
      bx <= bx_nxt;
      by <= by_nxt;
      dx <= dx_nxt;
      dy <= dy_nxt;
    end
  end

  assign de     = (sx_w < H_ACT_W) && (sy_w < V_ACT_W);
  assign hs_act = (sx_w >= HS_BEG) && (sx_w < HS_END);
  assign vs_act = (sy_w >= VS_BEG) && (sy_w < VS_END);
  assign in_box = (sx_w >= bx_w) && (sx_w < bx_w + BOX_W) &&
                  (sy_w >= by_w) && (sy_w < by_w + BOX_W);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W+2:0] H_ACT_P = (CNT_W+3)'(H_ACTIVE);
  logic [2:0] bar;
  logic [2:0] bar_on;  // {R,G,B} full-scale enables

  always_comb begin
    bar = 3'(({3'b000, sx} << 3) / H_ACT_P);
    case (bar)
      3'd0:    bar_on = 3'b111;  // white
      3'd1:    bar_on = 3'b110;  // yellow
      3'd2:    bar_on = 3'b011;  // cyan
      3'd3:    bar_on = 3'b010;  // green
      3'd4:    bar_on = 3'b101;  // magenta
      3'd5:    bar_on = 3'b100;  // red
      3'd6:    bar_on = 3'b001;  // blue
      default: bar_on = 3'b000;  // black
    endcase
    if (i_pattern_sel)
      bg_rgb = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}}, {COLOR_W{bar_on[0]}}};
    else
      bg_rgb = i_bg_rgb;
  end
`else
  assign bg_rgb = i_bg_rgb;
`endif

  assign pix_rgb = !de ? '0 : (in_box ? i_box_rgb : bg_rgb);

  // Output stage: pins and coordinates registered together so they stay aligned.
  always_ff @(posedge i_VGA_CLK or posedge i_rst) begin
    if (i_rst) begin
      o_VGA_R       <= '0;
      o_VGA_G       <= '0;
      o_VGA_B       <= '0;
      o_VGA_HS      <= ~SYNC_ON;
      o_VGA_VS      <= ~SYNC_ON;
      o_BLANK_N     <= 1'b0;
      o_SYNC_N      <= 1'b1;
      o_Sx          <= '0;
      o_Sy          <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_VGA_R       <= pix_rgb[3*COLOR_W-1:2*COLOR_W];
      o_VGA_G       <= pix_rgb[2*COLOR_W-1:COLOR_W];
      o_VGA_B       <= pix_rgb[COLOR_W-1:0];
      o_VGA_HS      <= hs_act ? SYNC_ON : ~SYNC_ON;
      o_VGA_VS      <= vs_act ? SYNC_ON : ~SYNC_ON;
      o_BLANK_N     <= de;
      o_SYNC_N      <= 1'b1;
      o_Sx          <= sx;
      o_Sy          <= sy;
      o_frame_start <= (sx == '0) && (sy == '0);
    end
  end

endmodule
